// File: rtl/uart_pkg.sv
// Shared UART message definitions: ASCII constants, message type, FSM encodings
// and the binary-to-ASCII-decimal helper used by both transmit and parse sides.
package uart_pkg;

  localparam logic [7:0] ASCII_LBRACE = 8'h7B;
  localparam logic [7:0] ASCII_RBRACE = 8'h7D;
  localparam logic [7:0] ASCII_COMMA  = 8'h2C;
  localparam logic [7:0] ASCII_R      = 8'h52;
  localparam logic [7:0] ASCII_C      = 8'h43;
  localparam logic [7:0] ASCII_V      = 8'h56;
  localparam logic [7:0] ASCII_ZERO   = 8'h30;

  localparam int unsigned MSG_LEN = 16;

  // Byte 0 of the message sits in the most significant byte.
  typedef logic [8*MSG_LEN-1:0] msg_t;

  // Per-byte serializer phases.
  typedef enum logic [1:0] {
    BitIdle,
    BitStart,
    BitData,
    BitStop
  } byte_state_e;

  // Message-level sequencing; the next-byte decision lives inside StBytes.
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFirst,
    StBytes,
    StFinish
  } msg_state_e;

  // Three zero-padded ASCII decimal digits, hundreds digit first.
  function automatic logic [23:0] bin8_to_ascii3(input logic [7:0] b);
    logic [7:0] h, t, o;
    h = b / 8'd100;
    t = (b / 8'd10) % 8'd10;
    o = b % 8'd10;
    return {ASCII_ZERO + h, ASCII_ZERO + t, ASCII_ZERO + o};
  endfunction

  // "{Rddd,Cddd,Vddd}" for the captured row, column and value.
  function automatic msg_t build_msg(input logic [7:0] r, input logic [7:0] c,
                                     input logic [7:0] v);
    return {ASCII_LBRACE, ASCII_R, bin8_to_ascii3(r), ASCII_COMMA,
            ASCII_C, bin8_to_ascii3(c), ASCII_COMMA,
            ASCII_V, bin8_to_ascii3(v), ASCII_RBRACE};
  endfunction

  // Select message byte idx (0 = first byte on the line).
  function automatic logic [7:0] msg_byte(input msg_t m, input logic [3:0] idx);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (idx == 4'(i)) b = m[8*(MSG_LEN-1-i) +: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. Accepts a new byte in idle, or during the last stop-bit
// clock so consecutive bytes go out with no idle gap.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUDRATE = 57_600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] data,
  output logic       tx_line,
  output logic       byte_busy,
  output logic       byte_done
);

  localparam int unsigned BIT_CYCLES = CLK_FREQ / BAUDRATE;
  localparam int unsigned CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_CYCLES - 1);

  byte_state_e      state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic             line_q, line_d;
  logic             baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  // Next-state: baud/bit counting and the registered line level.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    line_d  = line_q;
    if (state_q != BitIdle) baud_d = baud_last ? '0 : baud_q + 1'b1;
    case (state_q)
      BitIdle: begin
        if (send) begin
          state_d = BitStart;
          baud_d  = '0;
          data_d  = data;
          line_d  = 1'b0;
        end
      end
      BitStart: begin
        if (baud_last) begin
          state_d = BitData;
          bit_d   = '0;
          line_d  = data_q[0];
        end
      end
      BitData: begin
        if (baud_last) begin
          if (bit_q == 3'd7) begin
            state_d = BitStop;
            line_d  = 1'b1;
          end else begin
            bit_d  = bit_q + 3'd1;
            line_d = data_q[bit_q + 3'd1];
          end
        end
      end
      BitStop: begin
        if (baud_last) begin
          if (send) begin
            // Back-to-back: the next start bit begins on the very next clock.
            state_d = BitStart;
            data_d  = data;
            line_d  = 1'b0;
          end else begin
            state_d = BitIdle;
          end
        end
      end
      default: state_d = BitIdle;
    endcase
  end

  // State and counter registers; the line must idle high straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BitIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      line_q  <= line_d;
    end
  end

  assign tx_line   = line_q;
  assign byte_busy = (state_q != BitIdle);
  assign byte_done = (state_q == BitStop) && baud_last;

endmodule

// File: rtl/uart_msg_tx.sv
// Pixel message transmitter: captures row/col/val on a tx_start rising edge and
// sends "{Rddd,Cddd,Vddd}" as 16 back-to-back 8N1 bytes.
module uart_msg_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUDRATE = 57_600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] row,
  input  logic [7:0] col,
  input  logic [7:0] val,
  output logic       tx_line,
  output logic       busy,
  output logic       tx_done,
  output logic [4:0] byte_idx
);

  msg_state_e state_q, state_d;
  logic       start_q;
  logic [7:0] row_q, row_d, col_q, col_d, val_q, val_d;
  msg_t       msg_q, msg_d;
  logic [3:0] idx_q, idx_d;
  logic       send;
  logic [7:0] tx_data;
  logic       byte_busy;
  logic       byte_done;

  uart_tx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUDRATE (BAUDRATE)
  ) u_tx_byte (
    .clk       (clk),
    .reset     (reset),
    .send      (send),
    .data      (tx_data),
    .tx_line   (tx_line),
    .byte_busy (byte_busy),
    .byte_done (byte_done)
  );

  // Message FSM: capture, format, then hand bytes to the serializer in order.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    val_d   = val_q;
    msg_d   = msg_q;
    idx_d   = idx_q;
    send    = 1'b0;
    case (state_q)
      StIdle: begin
        // Rising edge only, so a held request yields a single message.
        if (tx_start && !start_q) begin
          row_d   = row;
          col_d   = col;
          val_d   = val;
          state_d = StLoad;
        end
      end
      StLoad: begin
        msg_d   = build_msg(row_q, col_q, val_q);
        idx_d   = '0;
        state_d = StFirst;
      end
      StFirst: begin
        send    = 1'b1;
        state_d = StBytes;
      end
      StBytes: begin
        if (byte_done) begin
          if (idx_q == 4'(MSG_LEN - 1)) begin
            state_d = StFinish;
          end else begin
            send  = 1'b1;
            idx_d = idx_q + 4'd1;
          end
        end else if (!byte_busy) begin
          // Serializer lost its byte; give up rather than hang.
          state_d = StIdle;
        end
      end
      StFinish: begin
        idx_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    tx_data = msg_byte(msg_q, idx_d);
  end

  // Message state, captured fields and request-edge history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      val_q   <= '0;
      msg_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= tx_start;
      row_q   <= row_d;
      col_q   <= col_d;
      val_q   <= val_d;
      msg_q   <= msg_d;
      idx_q   <= idx_d;
    end
  end

  assign busy     = (state_q == StFirst) || (state_q == StBytes);
  assign tx_done  = (state_q == StFinish);
  assign byte_idx = busy ? {1'b0, idx_q} : 5'd0;

endmodule
